// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if -- bus bundle between two upstream masters, the arbiter
// and the single downstream slave.
//   m_cyc/m_stb/m_we [2]     per-master cycle, strobe, write enable
//   m_adr [2*AW]             per-master address, master i at [i*AW +: AW]
//   m_dat_w [2*DW]           per-master write data, master i at [i*DW +: DW]
//   m_dat_r [DW]             read data broadcast to both masters
//   m_ack/m_err [2]          per-master acknowledge / error
//   s_cyc/s_stb/s_we         slave cycle, strobe, write enable
//   s_adr [AW], s_dat_w [DW] slave address / write data
//   s_dat_r [DW]             slave read data
//   s_ack/s_err              slave acknowledge / error
//   grant [2]                one-hot current owner, 0 when idle
// Modport slave is the arbiter's view; modport master is the surrounding
// masters-plus-slave environment.
interface dbus_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic [1:0]      m_cyc;
  logic [1:0]      m_stb;
  logic [1:0]      m_we;
  logic [2*AW-1:0] m_adr;
  logic [2*DW-1:0] m_dat_w;
  logic [DW-1:0]   m_dat_r;
  logic [1:0]      m_ack;
  logic [1:0]      m_err;
  logic            s_cyc;
  logic            s_stb;
  logic            s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack;
  logic            s_err;
  logic [1:0]      grant;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack, s_err,
    output m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w, grant
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack, s_err,
    input  m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w, grant
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter -- two-master to one-slave bus arbiter with round-robin
// contention resolution and locked ownership while m_cyc stays high.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      dbus_arbiter_if.slave: master-side requests, slave-side
//            responses and the one-hot grant status
// Optional: define ARB_TIMEOUT_EN to compile in a stall watchdog that
// errors the owning master after TIMEOUT stalled strobe cycles.
module dbus_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  dbus_arbiter_if.slave   bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dbus_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // index of the master granted most recently
  logic   owner_stb;
  logic   tmo;

  always_comb begin
    owner_stb = 1'b0;
    if (state_q == BUS0) owner_stb = bus.m_stb[0];
    if (state_q == BUS1) owner_stb = bus.m_stb[1];
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       stall;

  assign stall = owner_stb && !bus.s_ack && !bus.s_err;
  assign tmo   = stall && (cnt_q == 8'(TIMEOUT - 1));

  // Counter restarts on every ownership change, so each master's stall
  // window is measured from zero.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && stall) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next state: IDLE resolves contention against the last owner; a
  // releasing owner hands straight to a waiting master with no idle cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m_cyc == 2'b11) state_d = last_q ? BUS0 : BUS1;
        else if (bus.m_cyc[0])  state_d = BUS0;
        else if (bus.m_cyc[1])  state_d = BUS1;
      end
      BUS0: begin
        if (tmo)                 state_d = IDLE;
        else if (!bus.m_cyc[0])  state_d = bus.m_cyc[1] ? BUS1 : IDLE;
      end
      BUS1: begin
        if (tmo)                 state_d = IDLE;
        else if (!bus.m_cyc[1])  state_d = bus.m_cyc[0] ? BUS0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == BUS0) last_d = 1'b0;
      if (state_d == BUS1) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Datapath: owner's request passes through combinationally; responses
  // return only to the owner.
  always_comb begin
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.grant   = '0;
    bus.m_dat_r = bus.s_dat_r;
    unique case (state_q)
      BUS0: begin
        bus.s_cyc    = bus.m_cyc[0];
        bus.s_stb    = bus.m_stb[0];
        bus.s_we     = bus.m_we[0];
        bus.s_adr    = bus.m_adr[0 +: AW];
        bus.s_dat_w  = bus.m_dat_w[0 +: DW];
        bus.m_ack[0] = bus.s_ack;
        bus.m_err[0] = bus.s_err | tmo;
        bus.grant    = 2'b01;
      end
      BUS1: begin
        bus.s_cyc    = bus.m_cyc[1];
        bus.s_stb    = bus.m_stb[1];
        bus.s_we     = bus.m_we[1];
        bus.s_adr    = bus.m_adr[AW +: AW];
        bus.s_dat_w  = bus.m_dat_w[DW +: DW];
        bus.m_ack[1] = bus.s_ack;
        bus.m_err[1] = bus.s_err | tmo;
        bus.grant    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter AW, default 16: address width of all address ports.
REQ-002 Parameter DW, default 16: data width of all data ports.
REQ-003 Parameter TIMEOUT, default 16: stall limit in cycles when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 m_cyc  in  2  per-master bus cycle request; bit 0 is core dbus, bit 1 is loader/debug master.
REQ-007 m_stb  in  2  per-master transfer strobe.
REQ-008 m_we  in  2  per-master write enable.
REQ-009 m_adr  in  2*AW  per-master address; master i at [i*AW +: AW].
REQ-010 m_dat_w  in  2*DW  per-master write data; master i at [i*DW +: DW].
REQ-011 m_dat_r  out  DW  read data, broadcast to both masters.
REQ-012 m_ack  out  2  per-master acknowledge.
REQ-013 m_err  out  2  per-master error.
REQ-014 s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe and write enable.
REQ-015 s_adr  out  AW  slave address.
REQ-016 s_dat_w  out  DW  slave write data.
REQ-017 s_dat_r  in  DW  slave read data.
REQ-018 s_ack, s_err  in  1 each  slave acknowledge and slave error.
REQ-019 grant  out  2  one-hot owner status; 2'b00 when idle.

Function
REQ-020 FSM states SHALL be IDLE, BUS0 and BUS1; BUSi means master i owns the slave.
- IDLE -> BUSi when only m_cyc[i] is high.
- When both are high, IDLE SHALL go to the master not granted last (round-robin).
REQ-021 Grant latency SHALL be exactly one cycle: m_cyc sampled high at edge n gives s_cyc high after edge n.
REQ-022 In BUSi, s_cyc/s_stb/s_we/s_adr/s_dat_w SHALL combinationally follow master i, and grant SHALL equal 1<<i.
REQ-023 In IDLE, s_cyc, s_stb, s_we and grant SHALL be 0, and s_adr and s_dat_w SHALL be 0.
REQ-024 In BUSi, m_ack[i]=s_ack and m_err[i]=s_err; the other master's ack and err SHALL be 0; in IDLE, all m_ack and m_err SHALL be 0.
REQ-025 m_dat_r SHALL equal s_dat_r in every state.
REQ-026 Ownership SHALL persist while m_cyc[i] stays high, covering multiple strobes (locked read-modify-write).
REQ-027 When m_cyc[i] falls in BUSi, the next state SHALL be BUSj if m_cyc[j] (j≠i) is high, else IDLE; there is no dead cycle on handover.
REQ-028 A last-grant register SHALL update on every entry to BUSi.
REQ-029 Simultaneous s_ack and s_err SHALL be forwarded unchanged; resolving them is the slave's responsibility.

Reset
REQ-030 On reset_n low, the FSM SHALL go to IDLE immediately and asynchronously, with all outputs per REQ-023/024.
REQ-031 On reset_n low, last-grant SHALL be 1, so master 0 wins the first contention after reset.
REQ-032 On reset_n low, the timeout counter SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL drop s_cyc with no ack or err to either master.

Configuration
REQ-034 The timeout watchdog SHALL be compiled in when macro ARB_TIMEOUT_EN is defined.
- An 8-bit counter increments each cycle of BUSi with s_stb high and s_ack and s_err both low.
- The counter clears otherwise and on every state change.
- When the counter reaches TIMEOUT-1 with no ack or err, m_err[i] SHALL pulse for one cycle and the FSM SHALL go to IDLE at the next edge, regardless of m_cyc[i].
- After a timeout, master i SHALL NOT be regranted before the other master if the other is requesting.
REQ-035 Without ARB_TIMEOUT_EN, no counter SHALL exist and m_err SHALL be driven only by s_err per REQ-024.

Verification
REQ-036 Reset release, m_cyc=2'b11 at the same edge -> grant=2'b01 one cycle later; m0 read of adr 0x0010 returns s_dat_r=0xBEEF on m_ack[0] only.
REQ-037 m0 holds cyc over 3 strobes while m1 requests -> grant stays 2'b01 for all 3 acks; m0 cyc drop -> grant=2'b10 on the next cycle, with no IDLE cycle.
REQ-038 Both masters request continuously with single-strobe cycles -> grant alternates 01,10,01,10; each master receives exactly 4 acks in 8 transfers.
REQ-039 m1 write 0x1234 to 0x7FFE in progress, reset_n pulsed low mid-cycle -> s_cyc=0, m_ack=00, m_err=00 immediately; first grant after release goes to m0.
REQ-040 ARB_TIMEOUT_EN defined, TIMEOUT=16, slave never acks -> m_err[0] pulses on the 16th stalled cycle, then IDLE; undefined -> s_stb stays high indefinitely with no error.
REQ-041 s_err asserted on an m1 transfer -> m_err=2'b10 in the same cycle; m_ack=00.
